fifo_write_arbiter: RTL

//   Round-robin, packet-atomic write arbiter sharing one showahead sync FIFO between N_REQ producers.

---
 rtl/fifo_write_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
//   Round-robin, packet-atomic write arbiter that lets N_REQ producers share
//   one showahead sync FIFO. A grant is held for a whole packet (through
//   req_last) or MAX_BURST words, whichever ends first. Every grant costs one
//   IDLE bubble cycle. Writes are throttled by fifo_almost_full, so the FIFO
//   never holds more than DATA_DEPTH-1 words.
//
//   Optional feature macro: FIFO_ARB_STATS_EN
//     defined   : stat_words carries saturating per-requester accepted-word
//                 counters, cleared only by rst.
//     undefined : stat_words is tied to zero and no counter flops exist.
module fifo_write_arbiter #(
  parameter int N_REQ     = 4,
  parameter int W_DATA    = 32,
  parameter int MAX_BURST = 16,
  parameter int W_STAT    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*W_DATA-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  input  logic                      fifo_almost_full,
  output logic [W_DATA-1:0]         fifo_wr_data,
  output logic                      fifo_wr_en,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      busy,
  output logic [N_REQ*W_STAT-1:0]   stat_words
);

  localparam int GW = $clog2(N_REQ);
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] BURST_END = BW'(MAX_BURST - 1);
  localparam logic [GW-1:0] LAST_IDX  = GW'(N_REQ - 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t          state;
  logic [GW-1:0]   rr_ptr;
  logic [BW-1:0]   burst_cnt;
  logic            xfer;
  logic            pkt_end;

  // First valid requester found when scanning ptr, ptr+1, ... (mod N_REQ).
  function automatic logic [GW-1:0] rr_pick(input logic [N_REQ-1:0] v,
                                            input logic [GW-1:0]    ptr);
    logic [GW-1:0] pick;
    logic [GW-1:0] cand;
    logic          found;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = GW'((int'(ptr) + k) % N_REQ);
      if (!found && v[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Requester index following g, wrapping at N_REQ (N_REQ need not be 2^n).
  function automatic logic [GW-1:0] rr_next(input logic [GW-1:0] g);
    return (g == LAST_IDX) ? '0 : g + 1'b1;
  endfunction

  // Only the owner may see ready; rst blocks the write in the cycle it is asserted.
  always_comb begin
    req_ready = '0;
    if (busy && !fifo_almost_full && !rst) req_ready[grant_id] = 1'b1;
  end

  assign xfer         = |(req_valid & req_ready);
  assign pkt_end      = xfer && (req_last[grant_id] || (burst_cnt == BURST_END));
  assign fifo_wr_en   = xfer;
  assign fifo_wr_data = req_data[int'(grant_id)*W_DATA +: W_DATA];

  // Grant FSM: IDLE picks the round-robin winner, XFER holds it until packet end or burst limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      rr_ptr    <= '0;
      grant_id  <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            grant_id  <= rr_pick(req_valid, rr_ptr);
            burst_cnt <= '0;
            state     <= XFER;
            busy      <= 1'b1;
          end
        end
        XFER: begin
          if (xfer) begin
            burst_cnt <= burst_cnt + 1'b1;
            if (pkt_end) begin
              rr_ptr <= rr_next(grant_id);
              state  <= IDLE;
              busy   <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [W_STAT-1:0] stat_cnt [N_REQ];

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [W_STAT-1:0] sat_inc(input logic [W_STAT-1:0] c);
    return (c == {W_STAT{1'b1}}) ? c : c + 1'b1;
  endfunction

  // Per-requester accepted-word counters, bumped on every handshake of the owner.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (rst) begin
        stat_cnt[i] <= '0;
      end else if (xfer && (grant_id == GW'(i))) begin
        stat_cnt[i] <= sat_inc(stat_cnt[i]);
      end
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stat_pack
    assign stat_words[gi*W_STAT +: W_STAT] = stat_cnt[gi];
  end
`else
  assign stat_words = '0;
`endif

endmodule
